mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/sa_pkg.sv | 12 +
 rtl/mul_arbiter_multiply8.sv | 27 ++
 rtl/mul_arbiter.sv | 94 +++++++++
 tb/tb_mul_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared widths and the pipeline tag type for the shared-multiplier arbiter.
package sa_pkg;
  localparam int OPND_W   = 8;
  localparam int PROD_W   = 16;
  localparam int TAG_ID_W = 3;

  // The id field is sized for the largest supported requester count (8).
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/mul_arbiter_multiply8.sv
// Unsigned 8x8 multiplier, pipelined so the product appears MUL_LAT cycles after the operands.
module multiply8
  import sa_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  logic [PROD_W-1:0] stage [MUL_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= PROD_W'(a) * PROD_W'(b);
      for (int i = 1; i < MUL_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign p = stage[MUL_LAT-1];

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one pipelined 8x8 multiplier among NREQ requesters.
module mul_arbiter
  import sa_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*OPND_W-1:0]   req_a,
  input  logic [NREQ*OPND_W-1:0]   req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [PROD_W-1:0]        rsp_c,
  output logic                     busy,
  output logic [15:0]              op_count
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    grant_id;
  logic              transfer;
  int                scan_idx;
  logic [OPND_W-1:0] op_a;
  logic [OPND_W-1:0] op_b;
  tag_t              op_tag;
  tag_t              tag_pipe [MUL_LAT];
  logic [PROD_W-1:0] product;

  // First valid requester scanning upward from the one after the last winner.
  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    transfer  = 1'b0;
    scan_idx  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = (int'(ptr) + k) % NREQ;
      if (en && !rst && !transfer && req_valid[scan_idx]) begin
        req_ready[scan_idx] = 1'b1;
        grant_id            = IDW'(scan_idx);
        transfer            = 1'b1;
      end
    end
  end

  multiply8 #(.MUL_LAT(MUL_LAT)) u_mul (
    .clk (clk),
    .rst (rst),
    .a   (op_a),
    .b   (op_b),
    .p   (product)
  );

  // The tag travels beside the multiplier so id and product leave together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= IDW'(NREQ - 1);
      op_a      <= '0;
      op_b      <= '0;
      op_tag    <= '0;
      for (int i = 0; i < MUL_LAT; i++) tag_pipe[i] <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_c     <= '0;
      op_count  <= '0;
    end else begin
      if (transfer) begin
        ptr      <= grant_id;
        op_a     <= req_a[grant_id*OPND_W +: OPND_W];
        op_b     <= req_b[grant_id*OPND_W +: OPND_W];
        op_count <= op_count + 16'd1;
      end
      op_tag.valid <= transfer;
      op_tag.id    <= TAG_ID_W'(grant_id);
      tag_pipe[0]  <= op_tag;
      for (int i = 1; i < MUL_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      rsp_valid <= tag_pipe[MUL_LAT-1].valid;
      if (tag_pipe[MUL_LAT-1].valid) begin
        rsp_id <= IDW'(tag_pipe[MUL_LAT-1].id);
        rsp_c  <= product;
      end
    end
  end

  always_comb begin
    busy = op_tag.valid;
    for (int i = 0; i < MUL_LAT; i++) busy = busy | tag_pipe[i].valid;
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: single-op vector table plus multi-cycle sequences.
module tb_mul_arbiter;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_c;
  logic        busy;
  logic [15:0] op_count;

  int checks = 0;
  int passed = 0;
  int exp_ops = 0;
  int nresp;

  typedef struct {
    logic        en;
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_id;
    logic [15:0] exp_c;
  } vec_t;

  vec_t vecs [10];

  mul_arbiter #(.NREQ(4), .MUL_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_c     (rsp_c),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // One vector from idle: grant in cycle 0, response visible in cycle 4.
  task automatic applyStimulus(input vec_t v, input int n);
    logic xfer;
    en = v.en;
    req_valid = v.valid;
    req_a = v.a;
    req_b = v.b;
    #1;
    checkOutput($sformatf("vec%0d ready", n), 32'(req_ready), 32'(v.exp_ready));
    xfer = (v.exp_ready != 4'b0000);
    if (xfer) exp_ops++;
    @(negedge clk);
    req_valid = '0;
    en = 1'b1;
    checkOutput($sformatf("vec%0d busy_c1", n), 32'(busy), 32'(xfer));
    @(negedge clk);
    @(negedge clk);
    checkOutput($sformatf("vec%0d rsp_valid_c3", n), 32'(rsp_valid), 32'(0));
    @(negedge clk);
    checkOutput($sformatf("vec%0d rsp_valid_c4", n), 32'(rsp_valid), 32'(xfer));
    checkOutput($sformatf("vec%0d rsp_id", n), 32'(rsp_id), 32'(v.exp_id));
    checkOutput($sformatf("vec%0d rsp_c", n), 32'(rsp_c), 32'(v.exp_c));
    checkOutput($sformatf("vec%0d op_count", n), 32'(op_count), 32'(exp_ops));
    checkOutput($sformatf("vec%0d busy_c4", n), 32'(busy), 32'(0));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'b0001, 32'h0000_0003, 32'h0000_0005, 4'b0001, 2'd0, 16'h000F};
    vecs[1] = '{1'b1, 4'b0101, 32'h0000_00FF, 32'h007F_00FF, 4'b0100, 2'd2, 16'h0000};
    vecs[2] = '{1'b1, 4'b0101, 32'h0000_00FF, 32'h007F_00FF, 4'b0001, 2'd0, 16'hFE01};
    vecs[3] = '{1'b1, 4'b1000, 32'h1200_0000, 32'h3400_0000, 4'b1000, 2'd3, 16'h03A8};
    vecs[4] = '{1'b1, 4'b1010, 32'h0700_8000, 32'h0900_0200, 4'b0010, 2'd1, 16'h0100};
    vecs[5] = '{1'b1, 4'b0000, 32'h0101_0101, 32'h0101_0101, 4'b0000, 2'd1, 16'h0100};
    vecs[6] = '{1'b0, 4'b1111, 32'h0101_0101, 32'h0101_0101, 4'b0000, 2'd1, 16'h0100};
    vecs[7] = '{1'b1, 4'b0110, 32'h00FF_0F00, 32'h0001_1100, 4'b0100, 2'd2, 16'h00FF};
    vecs[8] = '{1'b1, 4'b0011, 32'h0000_10AA, 32'h0000_1055, 4'b0001, 2'd0, 16'h3872};
    vecs[9] = '{1'b1, 4'b0011, 32'h0000_10AA, 32'h0000_1055, 4'b0010, 2'd1, 16'h0100};

    rst = 1'b1;
    en = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    @(negedge clk);
    checkOutput("reset req_ready", 32'(req_ready), 32'(0));
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("reset rsp_id", 32'(rsp_id), 32'(0));
    checkOutput("reset rsp_c", 32'(rsp_c), 32'(0));
    checkOutput("reset busy", 32'(busy), 32'(0));
    checkOutput("reset op_count", 32'(op_count), 32'(0));
    rst = 1'b0;

    for (int n = 0; n < 10; n++) applyStimulus(vecs[n], n);

    // All four requesters streaming: strict rotation and in-order responses.
    doReset();
    for (int k = 0; k < 13; k++) begin
      if (k >= 4 && k <= 11) begin
        checkOutput($sformatf("stream rsp_valid k%0d", k), 32'(rsp_valid), 32'(1));
        checkOutput($sformatf("stream rsp_id k%0d", k), 32'(rsp_id), 32'((k - 4) % 4));
        checkOutput($sformatf("stream rsp_c k%0d", k), 32'(rsp_c), 32'(((k - 4) % 4 + 1) * 16));
      end else if (k == 12) begin
        checkOutput("stream rsp_valid end", 32'(rsp_valid), 32'(0));
      end
      en = 1'b1;
      req_valid = (k < 8) ? 4'hF : 4'h0;
      req_a = 32'h0403_0201;
      req_b = 32'h1010_1010;
      #1;
      if (k < 8) checkOutput($sformatf("stream ready k%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      @(negedge clk);
    end

    // Max operands from requester 0, then requester 2 back-to-back.
    req_valid = 4'b0101;
    req_a = 32'h0000_00FF;
    req_b = 32'h007F_00FF;
    #1;
    checkOutput("pair ready0", 32'(req_ready), 32'(4'b0001));
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    checkOutput("pair ready2", 32'(req_ready), 32'(4'b0100));
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pair rsp_valid0", 32'(rsp_valid), 32'(1));
    checkOutput("pair rsp_id0", 32'(rsp_id), 32'(0));
    checkOutput("pair rsp_c0", 32'(rsp_c), 32'(16'hFE01));
    @(negedge clk);
    checkOutput("pair rsp_valid2", 32'(rsp_valid), 32'(1));
    checkOutput("pair rsp_id2", 32'(rsp_id), 32'(2));
    checkOutput("pair rsp_c2", 32'(rsp_c), 32'(0));
    @(negedge clk);
    checkOutput("pair rsp_valid idle", 32'(rsp_valid), 32'(0));
    checkOutput("pair rsp_id hold", 32'(rsp_id), 32'(2));

    // en drops after two grants; only in-flight work completes.
    nresp = 0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid) nresp++;
      if (k == 4) begin
        checkOutput("en_drop rsp_id3", 32'(rsp_id), 32'(3));
        checkOutput("en_drop rsp_c3", 32'(rsp_c), 32'(8));
        checkOutput("en_drop busy c4", 32'(busy), 32'(1));
      end
      if (k == 5) begin
        checkOutput("en_drop rsp_id0", 32'(rsp_id), 32'(0));
        checkOutput("en_drop rsp_c0", 32'(rsp_c), 32'(2));
        checkOutput("en_drop busy c5", 32'(busy), 32'(0));
      end
      en = (k < 2);
      req_valid = 4'hF;
      req_a = 32'h0403_0201;
      req_b = 32'h0202_0202;
      #1;
      if (k < 6)
        checkOutput($sformatf("en_drop ready k%0d", k), 32'(req_ready),
                    32'((k == 0) ? 4'b1000 : (k == 1) ? 4'b0001 : 4'b0000));
      @(negedge clk);
    end
    checkOutput("en_drop response count", 32'(nresp), 32'(2));
    req_valid = '0;
    en = 1'b1;

    // Reset with two operations in flight.
    req_valid = 4'hF;
    #1;
    checkOutput("flush ready1", 32'(req_ready), 32'(4'b0010));
    @(negedge clk);
    #1;
    checkOutput("flush ready2", 32'(req_ready), 32'(4'b0100));
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    checkOutput("flush busy", 32'(busy), 32'(0));
    checkOutput("flush op_count", 32'(op_count), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    nresp = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) nresp++;
    end
    checkOutput("flush stray responses", 32'(nresp), 32'(0));
    req_valid = 4'hF;
    #1;
    checkOutput("flush next grant", 32'(req_ready), 32'(4'b0001));
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("flush rsp_valid", 32'(rsp_valid), 32'(1));
    checkOutput("flush rsp_c", 32'(rsp_c), 32'(2));
    checkOutput("flush op_count after", 32'(op_count), 32'(1));

    // op_count wrap.
    doReset();
    checkOutput("wrap start", 32'(op_count), 32'(0));
    req_valid = 4'b0001;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    checkOutput("wrap FFFF", 32'(op_count), 32'(16'hFFFF));
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    checkOutput("wrap 0000", 32'(op_count), 32'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
